// File: rtl/ternary_requant.sv
`default_nettype none
// ============================================================================
//  Module      : ternary_requant
//  Description : Two-stage requantizer. Shifts a balanced-ternary accumulator
//                down, applies optional ReLU and saturates it to an activation.
//  Revision    : 1.0 - initial release
// ============================================================================
module ternary_requant #(
    parameter int ACC_WIDTH = 27,
    parameter int ACT_WIDTH = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ACC_WIDTH-1:0][1:0]  in_acc,
    input  logic [4:0]                 in_shift,
    input  logic                       in_relu,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACT_WIDTH-1:0][1:0]  out_act,
    output logic                       out_sat,
    input  logic                       cnt_clr,
    output logic [CNT_WIDTH-1:0]       sat_count
);

    localparam logic [1:0] c_T_ZERO = 2'b00;
    localparam logic [1:0] c_T_POS  = 2'b01;
    localparam logic [1:0] c_T_NEG  = 2'b10;
    localparam int         c_K_MAX_INT = ACC_WIDTH - ACT_WIDTH;
    localparam logic [4:0] c_K_MAX = (c_K_MAX_INT > 31) ? 5'd31 : 5'(c_K_MAX_INT);

    logic                       w_s1_adv;
    logic                       w_out_xfer;
    logic [4:0]                 w_k;
    logic [ACC_WIDTH-1:0][1:0]  w_clean;
    logic [ACC_WIDTH-1:0][1:0]  w_shifted;
    logic [1:0]                 w_hi_sign;
    logic [1:0]                 w_all_sign;
    logic [ACT_WIDTH-1:0][1:0]  w_act;
    logic                       w_sat;

    logic                       r_s1_valid;
    logic [ACC_WIDTH-1:0][1:0]  r_s1_trits;
    logic                       r_s1_relu;
    logic                       r_s2_valid;
    logic [ACT_WIDTH-1:0][1:0]  r_out_act;
    logic                       r_out_sat;
    logic [CNT_WIDTH-1:0]       r_sat_count;

    assign w_s1_adv   = !r_s2_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s1_adv;
    assign w_out_xfer = r_s2_valid && out_ready;

    // The unused trit code 2'b11 is folded to zero before anything else sees it
    for (genvar i = 0; i < ACC_WIDTH; i++) begin : g_clean
        assign w_clean[i] = (in_acc[i] == 2'b11) ? c_T_ZERO : in_acc[i];
    end

    // Dropping low trits of a balanced-ternary number is round-to-nearest
    assign w_k       = (in_shift > c_K_MAX) ? c_K_MAX : in_shift;
    assign w_shifted = w_clean >> {w_k, 1'b0};

    // The sign of a balanced-ternary number is the sign of its top nonzero trit.
    // Any nonzero trit above the activation width means the value is out of range.
    always_comb begin
        w_hi_sign  = c_T_ZERO;
        w_all_sign = c_T_ZERO;
        for (int i = 0; i < ACC_WIDTH; i++) begin
            if (r_s1_trits[i] != c_T_ZERO) begin
                w_all_sign = r_s1_trits[i];
                if (i >= ACT_WIDTH) begin
                    w_hi_sign = r_s1_trits[i];
                end
            end
        end

        w_act = r_s1_trits[ACT_WIDTH-1:0];
        w_sat = 1'b0;
        if (r_s1_relu && (w_all_sign == c_T_NEG)) begin
            w_act = '0;
        end else if (w_hi_sign == c_T_POS) begin
            w_act = {ACT_WIDTH{c_T_POS}};
            w_sat = 1'b1;
        end else if (w_hi_sign == c_T_NEG) begin
            w_act = {ACT_WIDTH{c_T_NEG}};
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_trits <= '0;
            r_s1_relu  <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_trits <= w_shifted;
                r_s1_relu  <= in_relu;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_out_act  <= '0;
            r_out_sat  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_act <= w_act;
                r_out_sat <= w_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_sat_count <= '0;
        end else if (w_out_xfer && r_out_sat && (r_sat_count != {CNT_WIDTH{1'b1}})) begin
            r_sat_count <= r_sat_count + 1'b1;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_act   = r_out_act;
    assign out_sat   = r_out_sat;
    assign sat_count = r_sat_count;

endmodule
`default_nettype wire
